// File: rtl/div_unit.sv
// Iterative radix-2 restoring divider for RV32M DIV/DIVU/REM/REMU.
// One quotient bit per cycle; divide-by-zero and signed overflow resolve at accept.
module div_unit #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  CLK,
  input  logic                  RESET,
  input  logic                  START,
  input  logic                  FLUSH,
  input  logic [4:0]            ALUOP,
  input  logic [DATA_WIDTH-1:0] DATA1,
  input  logic [DATA_WIDTH-1:0] DATA2,
  output logic [DATA_WIDTH-1:0] RESULT,
  output logic                  BUSY,
  output logic                  DONE
);

  localparam int W  = DATA_WIDTH;
  localparam int CW = $clog2(DATA_WIDTH);
  localparam logic [CW-1:0] LAST_ITER = CW'(DATA_WIDTH - 1);
  localparam logic [W-1:0]  MOST_NEG  = {1'b1, {(W-1){1'b0}}};

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIN, S_DONE} state_t;

  state_t        state_q, state_d;
  logic          op_rem_q, op_rem_d;
  logic          neg_quo_q, neg_quo_d;
  logic          neg_rem_q, neg_rem_d;
  logic [W-1:0]  divisor_q, divisor_d;
  logic [W:0]    rem_q, rem_d;
  logic [W-1:0]  quo_q, quo_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [W-1:0]  result_q, result_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;

  logic          is_div_op;
  logic          is_signed_op;
  logic          accept;
  logic [W-1:0]  abs_a;
  logic [W-1:0]  abs_b;
  logic [W+1:0]  shifted;
  logic [W+1:0]  trial;

  always_comb begin
    state_d   = state_q;
    op_rem_d  = op_rem_q;
    neg_quo_d = neg_quo_q;
    neg_rem_d = neg_rem_q;
    divisor_d = divisor_q;
    rem_d     = rem_q;
    quo_d     = quo_q;
    cnt_d     = cnt_q;
    result_d  = result_q;

    // ALUOP = {funct3, funct7[5], funct7[0]}; divides are funct3=1xx with M-extension bit set
    is_div_op    = ALUOP[4] & (ALUOP[1:0] == 2'b01);
    is_signed_op = ~ALUOP[2];
    accept       = START & ~FLUSH & is_div_op &
                   ((state_q == S_IDLE) | (state_q == S_DONE));
    abs_a        = (is_signed_op & DATA1[W-1]) ? -DATA1 : DATA1;
    abs_b        = (is_signed_op & DATA2[W-1]) ? -DATA2 : DATA2;

    // One extra guard bit above the remainder so the trial sign is unambiguous
    shifted = {rem_q, quo_q[W-1]};
    trial   = shifted - {2'b00, divisor_q};

    case (state_q)
      S_IDLE, S_DONE: begin
        state_d = S_IDLE;
        if (accept) begin
          op_rem_d  = ALUOP[3];
          neg_quo_d = is_signed_op & (DATA1[W-1] ^ DATA2[W-1]);
          neg_rem_d = is_signed_op & DATA1[W-1];
          divisor_d = abs_b;
          quo_d     = abs_a;
          rem_d     = '0;
          cnt_d     = '0;
          if (DATA2 == '0) begin
            result_d = ALUOP[3] ? DATA1 : '1;
            state_d  = S_DONE;
          end else if (is_signed_op && DATA1 == MOST_NEG && DATA2 == '1) begin
            result_d = ALUOP[3] ? '0 : MOST_NEG;
            state_d  = S_DONE;
          end else begin
            state_d = S_CALC;
          end
        end
      end
      S_CALC: begin
        if (FLUSH) begin
          state_d = S_IDLE;
        end else begin
          quo_d = {quo_q[W-2:0], ~trial[W+1]};
          rem_d = trial[W+1] ? shifted[W:0] : trial[W:0];
          cnt_d = cnt_q + CW'(1);
          if (cnt_q == LAST_ITER) state_d = S_FIN;
        end
      end
      S_FIN: begin
        if (FLUSH) begin
          state_d = S_IDLE;
        end else begin
          if (op_rem_q) result_d = neg_rem_q ? -rem_q[W-1:0] : rem_q[W-1:0];
          else          result_d = neg_quo_q ? -quo_q : quo_q;
          state_d = S_DONE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d == S_CALC) | (state_d == S_FIN);
    done_d = (state_d == S_DONE);
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q   <= S_IDLE;
      op_rem_q  <= 1'b0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
      divisor_q <= '0;
      rem_q     <= '0;
      quo_q     <= '0;
      cnt_q     <= '0;
      result_q  <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      op_rem_q  <= op_rem_d;
      neg_quo_q <= neg_quo_d;
      neg_rem_q <= neg_rem_d;
      divisor_q <= divisor_d;
      rem_q     <= rem_d;
      quo_q     <= quo_d;
      cnt_q     <= cnt_d;
      result_q  <= result_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign RESULT = result_q;
  assign BUSY   = busy_q;
  assign DONE   = done_q;

endmodule

// File: tb/tb_div_unit.sv
// Self-checking bench for div_unit: directed plan cases, control corner cases,
// and random operations checked against an arithmetic reference model.
module tb_div_unit;

  localparam logic [4:0] OP_DIV  = 5'b10001;
  localparam logic [4:0] OP_DIVU = 5'b10101;
  localparam logic [4:0] OP_REM  = 5'b11001;
  localparam logic [4:0] OP_REMU = 5'b11101;

  logic        clk = 1'b0;
  logic        reset, start, flush;
  logic [4:0]  aluop;
  logic [31:0] data1, data2;
  logic [31:0] result;
  logic        busy, done;

  int          n_cmp = 0;
  int          n_bad = 0;
  logic [31:0] last_res;

  div_unit #(.DATA_WIDTH(32)) dut (
    .CLK(clk), .RESET(reset), .START(start), .FLUSH(flush), .ALUOP(aluop),
    .DATA1(data1), .DATA2(data2), .RESULT(result), .BUSY(busy), .DONE(done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference: RISC-V M semantics computed with wide signed arithmetic
  function automatic logic [31:0] ref_result(input logic [4:0] op, input logic [31:0] a,
                                              input logic [31:0] b);
    longint sa, sb;
    logic   is_rem = op[3];
    if (b == 32'd0) return is_rem ? a : 32'hFFFF_FFFF;
    if (op[2]) return is_rem ? (a % b) : (a / b);
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    return is_rem ? 32'(sa % sb) : 32'(sa / sb);
  endfunction

  function automatic bit ref_special(input logic [4:0] op, input logic [31:0] a,
                                     input logic [31:0] b);
    return (b == 32'd0) || (!op[2] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
  endfunction

  task automatic start_op(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
    start = 1'b1; aluop = op; data1 = a; data2 = b;
    @(negedge clk);
    start = 1'b0; aluop = 5'b00000;
  endtask

  task automatic wait_done(input string tag, input logic [31:0] exp, input int exp_lat,
                           input int exp_busy);
    int cyc = 1;
    int nb  = 0;
    while (done !== 1'b1 && cyc < 100) begin
      if (busy === 1'b1) nb++;
      @(negedge clk);
      cyc++;
    end
    chk({tag, "_done"}, 32'(done), 32'd1);
    chk({tag, "_lat"}, 32'(cyc), 32'(exp_lat));
    chk({tag, "_busy"}, 32'(nb), 32'(exp_busy));
    chk({tag, "_res"}, result, exp);
    $display("op %s: result=%h expected=%h latency=%0d", tag, result, exp, cyc);
  endtask

  task automatic run_op(input string tag, input logic [4:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp);
    bit sp = ref_special(op, a, b);
    start_op(op, a, b);
    wait_done(tag, exp, sp ? 1 : 34, sp ? 0 : 33);
    last_res = exp;
    @(negedge clk);
    chk({tag, "_pulse"}, 32'(done), 32'd0);
  endtask

  task automatic count_done(input string tag, input int cycles);
    int hits = 0;
    repeat (cycles) begin
      @(negedge clk);
      if (done === 1'b1) hits++;
    end
    chk(tag, 32'(hits), 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [4:0]  ops [4];
    logic [4:0]  op;
    logic [31:0] a, b;
    ops[0] = OP_DIV; ops[1] = OP_DIVU; ops[2] = OP_REM; ops[3] = OP_REMU;

    reset = 1'b1; start = 1'b0; flush = 1'b0; aluop = 5'b0; data1 = '0; data2 = '0;
    repeat (3) @(negedge clk);
    chk("rst_result", result, 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    reset = 1'b0;
    @(negedge clk);

    run_op("div_100_7",  OP_DIV,  32'd100, 32'd7, 32'd14);
    run_op("rem_100_7",  OP_REM,  32'd100, 32'd7, 32'd2);
    run_op("rem_m100_7", OP_REM,  -32'sd100, 32'd7, 32'hFFFF_FFFE);
    run_op("div_m100_7", OP_DIV,  -32'sd100, 32'd7, 32'hFFFF_FFF2);
    run_op("divu_max_2", OP_DIVU, 32'hFFFF_FFFF, 32'd2, 32'h7FFF_FFFF);
    run_op("div_5_0",    OP_DIV,  32'd5, 32'd0, 32'hFFFF_FFFF);
    run_op("remu_5_0",   OP_REMU, 32'd5, 32'd0, 32'd5);
    run_op("rem_m5_0",   OP_REM,  -32'sd5, 32'd0, 32'hFFFF_FFFB);
    run_op("div_ovf",    OP_DIV,  32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000);
    run_op("rem_ovf",    OP_REM,  32'h8000_0000, 32'hFFFF_FFFF, 32'd0);

    // Flush at CALC cycle 10: no completion, result held
    start_op(OP_DIV, 32'd1000, 32'd3);
    repeat (9) @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    chk("flush_busy", 32'(busy), 32'd0);
    chk("flush_result", result, last_res);
    count_done("flush_nodone", 40);
    $display("op flush_calc: busy=%b result=%h", busy, result);

    // Non-divide opcodes are ignored
    start_op(5'b00000, 32'd9, 32'd3);
    chk("nondiv_busy", 32'(busy), 32'd0);
    start_op(5'b10011, 32'd9, 32'd3);
    chk("nondiv2_busy", 32'(busy), 32'd0);
    count_done("nondiv_nodone", 5);
    $display("op nondiv_ignored: busy=%b", busy);

    // START during CALC is ignored; the first operation completes untouched
    start_op(OP_DIVU, 32'd1000, 32'd9);
    repeat (4) @(negedge clk);
    start_op(OP_REMU, 32'd77, 32'd5);
    wait_done("start_in_calc", 32'd111, 29, 28);
    last_res = 32'd111;
    @(negedge clk);

    // START+FLUSH in the DONE cycle: DONE completes, no new accept
    start_op(OP_DIVU, 32'd9, 32'd0);
    wait_done("flush_in_done", 32'hFFFF_FFFF, 1, 0);
    start = 1'b1; flush = 1'b1; aluop = OP_DIV; data1 = 32'd50; data2 = 32'd5;
    @(negedge clk);
    start = 1'b0; flush = 1'b0; aluop = 5'b0;
    chk("flushdone_busy", 32'(busy), 32'd0);
    chk("flushdone_result", result, 32'hFFFF_FFFF);
    count_done("flushdone_nodone", 5);

    // Reset at CALC cycle 20
    start_op(OP_DIV, 32'd1000, 32'd7);
    repeat (19) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("midrst_result", result, 32'd0);
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_done", 32'(done), 32'd0);
    reset = 1'b0;
    count_done("midrst_nodone", 40);
    $display("op reset_in_calc: result=%h busy=%b", result, busy);

    // Back-to-back: second request launched in the DONE cycle
    start_op(OP_DIV, 32'd100, 32'd7);
    wait_done("b2b_first", 32'd14, 34, 33);
    start_op(OP_REMU, 32'd12345, 32'd100);
    wait_done("b2b_second", 32'd45, 34, 33);
    @(negedge clk);
    chk("b2b_pulse", 32'(done), 32'd0);

    // Random operations against the reference model
    for (int i = 0; i < 60; i++) begin
      op = ops[$urandom_range(0, 3)];
      a  = $urandom();
      b  = $urandom() >> $urandom_range(0, 31);
      case ($urandom_range(0, 9))
        0:       b = 32'd0;
        1:       begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
        2:       begin a = $urandom_range(0, 1000); b = $urandom_range(1, 20); end
        3:       b = -($urandom_range(1, 50));
        default: ;
      endcase
      run_op($sformatf("rand%0d", i), op, a, b, ref_result(op, a, b));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/div_unit.md
Name: div_unit

Overview:
- Iterative RV32M divider for the EX stage. It executes DIV, DIVU, REM and REMU.
- It consumes the 5-bit ALUOP code from the decode stage, encoded as {FUNCT3, FUNCT7[5], FUNCT7[0]}, together with the two operands. It produces one 32-bit result after a multi-cycle radix-2 restoring division.
- The hazard unit stalls the pipeline on START & ~DONE.
- The single-cycle ALU handles all other ALUOP codes; this block ignores them.

Parameters:
- DATA_WIDTH, 32, operand and result width. Iteration count equals DATA_WIDTH.

Ports:
- CLK  input  1  clock; all state updates on the rising edge.
- RESET  input  1  synchronous, active-high reset.
- START  input  1  request; sampled only in IDLE or DONE state.
- FLUSH  input  1  abort the current operation (branch mispredict or pipeline flush).
- ALUOP  input  5  operation code. 10001=DIV, 10101=DIVU, 11001=REM, 11101=REMU. Any other value means not a divide.
- DATA1  input  DATA_WIDTH  dividend (rs1).
- DATA2  input  DATA_WIDTH  divisor (rs2).
- RESULT  output  DATA_WIDTH  quotient or remainder.
- BUSY  output  1  high while iterating.
- DONE  output  1  one-cycle pulse; RESULT is valid in that cycle.

Behaviour:
- Reset is synchronous and active-high (RESET, sampled on the CLK rising edge). It takes priority over everything else.
  - State goes to IDLE, iteration counter to 0, RESULT to 0, BUSY to 0, DONE to 0.
  - Reset mid-operation discards the operation with no DONE.
- States: IDLE, CALC, FIN, DONE.
- Acceptance:
  - A request is accepted when START=1, FLUSH=0, the state is IDLE or DONE, and ALUOP is one of the four divide codes.
  - START with a non-divide ALUOP is ignored and the state does not change.
  - START in CALC or FIN is ignored.
- On accept:
  - Latch the opcode.
  - Signed ops (DIV, REM): latch |DATA1| and |DATA2|, plus the sign flags sign(DATA1) and sign(DATA1)^sign(DATA2).
  - Unsigned ops: latch the raw operands.
  - Clear the partial remainder and counter.
- Special cases are decided at accept and skip CALC; the next state is DONE, with DONE high on the cycle after accept.
  - Divide by zero (DATA2==0): quotient is all ones (0xFFFFFFFF) for both DIV and DIVU. Remainder is DATA1 unmodified for both REM and REMU.
  - Signed overflow (DIV/REM with DATA1=0x80000000 and DATA2=0xFFFFFFFF): quotient is 0x80000000, remainder is 0.
  - Divide-by-zero check takes precedence over overflow.
- CALC, one bit per cycle for DATA_WIDTH cycles:
  - Shift {rem, quo} left by 1.
  - trial = rem - divisor, evaluated as DATA_WIDTH+1 bits.
  - If trial is non-negative: rem = trial and quo[0] = 1.
  - Counter increments; after iteration DATA_WIDTH-1 the next state is FIN.
- FIN: apply sign correction and register RESULT.
  - DIV: negate the quotient if the sign flags differ.
  - REM: negate the remainder if the dividend was negative.
  - Next state is DONE.
- DONE:
  - DONE=1 for exactly one cycle; next state is IDLE unless a new request is accepted.
  - A new request in this cycle is accepted, giving back-to-back operation.
- Latency, normal path: START accepted at edge 0; BUSY=1 in the cycles after edges 0..DATA_WIDTH (CALC and FIN); DONE=1 in the cycle after edge DATA_WIDTH+1. For DATA_WIDTH=32, DONE appears 34 cycles after the accepting edge.
- BUSY=1 in CALC and FIN, 0 in IDLE and DONE.
- RESULT holds its last value until the next FIN or special-case update. It is not cleared on DONE exit.
- FLUSH:
  - In CALC or FIN: next state is IDLE, no DONE, RESULT unchanged.
  - In DONE: DONE still completes this cycle, and no new request is accepted.
  - FLUSH together with START: no accept; FLUSH wins.
- Intermediate arithmetic: remainder register DATA_WIDTH+1 bits; all negation in two's complement at DATA_WIDTH bits.

Test Plan:
- DIV 100/7 (ALUOP=10001): BUSY for 33 cycles, then DONE pulse with RESULT=14 exactly 34 cycles after accept. REM with the same operands: RESULT=2.
- Signed operands:
  - REM -100/7: RESULT=0xFFFFFFFE.
  - DIV -100/7: RESULT=0xFFFFFFF2.
  - DIVU 0xFFFFFFFF/2 (10101): RESULT=0x7FFFFFFF.
- Divide by zero, each giving DONE one cycle after accept with BUSY never high:
  - DIV 5/0: RESULT=0xFFFFFFFF.
  - REMU 5/0 (11101): RESULT=5.
  - REM -5/0: RESULT=0xFFFFFFFB.
- Overflow: DIV 0x80000000/0xFFFFFFFF gives 0x80000000; REM with the same operands gives 0. Both complete in 1 cycle.
- Control:
  - FLUSH at cycle 10 of CALC: BUSY=0 on the next cycle, no DONE, RESULT keeps its previous value.
  - START with ALUOP=00000 is ignored.
  - START during CALC is ignored.
- Reset and back-to-back:
  - RESET at cycle 20 of CALC: all outputs 0 the next cycle.
  - START asserted during the DONE cycle: a second DONE arrives 34 cycles later with the correct value.
